// File: rtl/ws2812b_pixel_assembler.sv
// WS2812B pixel assembler: packs decoded bits into 24-bit GRB pixels, numbers them per frame,
// detects the latch gap and captures one selected pixel. Optional: `WS2812B_PARTIAL_ERR_EN.
module ws2812b_pixel_assembler #(
  parameter int unsigned IDX_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_valid,
  input  logic             bit_value,
  input  logic [15:0]      gap_cycles,
  input  logic [IDX_W-1:0] led_select,
  output logic             pixel_valid,
  output logic [23:0]      pixel_grb,
  output logic [IDX_W-1:0] pixel_index,
  output logic             frame_done,
  output logic [IDX_W-1:0] frame_pixels,
  output logic             idx_overflow,
  output logic [23:0]      sel_grb,
  output logic             sel_update,
  output logic             partial_err
);

  localparam logic [0:0]       S_IDLE    = 1'b0;
  localparam logic [0:0]       S_RECEIVE = 1'b1;
  localparam logic [IDX_W-1:0] IDX_MAX   = '1;

  logic [0:0]       state_q, state_d;
  logic [22:0]      shreg_q, shreg_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      idle_cnt_q, idle_cnt_d;
  logic             pixel_valid_q, pixel_valid_d;
  logic [23:0]      pixel_grb_q, pixel_grb_d;
  logic [IDX_W-1:0] pixel_index_q, pixel_index_d;
  logic             frame_done_q, frame_done_d;
  logic [IDX_W-1:0] frame_pixels_q, frame_pixels_d;
  logic             idx_overflow_q, idx_overflow_d;
  logic [23:0]      sel_grb_q, sel_grb_d;
  logic             sel_update_q, sel_update_d;
  logic [15:0]      gap_thresh;
`ifdef WS2812B_PARTIAL_ERR_EN
  logic             partial_err_q, partial_err_d;
`endif

  // idle_cnt holds (idle cycles - 1) while counting, so the gap completes when it reaches gap-1;
  // a zero gap behaves as one.
  assign gap_thresh = (gap_cycles == 16'd0) ? 16'd0 : gap_cycles - 16'd1;

  always_comb begin
    state_d        = state_q;
    shreg_d        = shreg_q;
    bit_cnt_d      = bit_cnt_q;
    idx_d          = idx_q;
    idle_cnt_d     = idle_cnt_q;
    pixel_valid_d  = 1'b0;
    pixel_grb_d    = pixel_grb_q;
    pixel_index_d  = pixel_index_q;
    frame_done_d   = 1'b0;
    frame_pixels_d = frame_pixels_q;
    idx_overflow_d = idx_overflow_q;
    sel_grb_d      = sel_grb_q;
    sel_update_d   = 1'b0;
`ifdef WS2812B_PARTIAL_ERR_EN
    partial_err_d  = 1'b0;
`endif
    if (bit_valid) begin
      state_d    = S_RECEIVE;
      idle_cnt_d = '0;
      shreg_d    = {shreg_q[21:0], bit_value};
      if (bit_cnt_q == 5'd23) begin
        bit_cnt_d     = '0;
        pixel_valid_d = 1'b1;
        pixel_grb_d   = {shreg_q, bit_value};
        pixel_index_d = idx_q;
        if (idx_q == led_select) begin
          sel_grb_d    = {shreg_q, bit_value};
          sel_update_d = 1'b1;
        end
        if (idx_q == IDX_MAX) begin
          idx_overflow_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 5'd1;
      end
    end else if (state_q == S_RECEIVE) begin
      if (idle_cnt_q >= gap_thresh) begin
        frame_done_d   = 1'b1;
        frame_pixels_d = idx_q;
        idx_d          = '0;
        bit_cnt_d      = '0;
        shreg_d        = '0;
        idx_overflow_d = 1'b0;
        idle_cnt_d     = '0;
        state_d        = S_IDLE;
`ifdef WS2812B_PARTIAL_ERR_EN
        partial_err_d  = (bit_cnt_q != 5'd0);
`endif
      end else if (idle_cnt_q != '1) begin
        idle_cnt_d = idle_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      shreg_q        <= '0;
      bit_cnt_q      <= '0;
      idx_q          <= '0;
      idle_cnt_q     <= '0;
      pixel_valid_q  <= 1'b0;
      pixel_grb_q    <= '0;
      pixel_index_q  <= '0;
      frame_done_q   <= 1'b0;
      frame_pixels_q <= '0;
      idx_overflow_q <= 1'b0;
      sel_grb_q      <= '0;
      sel_update_q   <= 1'b0;
`ifdef WS2812B_PARTIAL_ERR_EN
      partial_err_q  <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      shreg_q        <= shreg_d;
      bit_cnt_q      <= bit_cnt_d;
      idx_q          <= idx_d;
      idle_cnt_q     <= idle_cnt_d;
      pixel_valid_q  <= pixel_valid_d;
      pixel_grb_q    <= pixel_grb_d;
      pixel_index_q  <= pixel_index_d;
      frame_done_q   <= frame_done_d;
      frame_pixels_q <= frame_pixels_d;
      idx_overflow_q <= idx_overflow_d;
      sel_grb_q      <= sel_grb_d;
      sel_update_q   <= sel_update_d;
`ifdef WS2812B_PARTIAL_ERR_EN
      partial_err_q  <= partial_err_d;
`endif
    end
  end

  assign pixel_valid  = pixel_valid_q;
  assign pixel_grb    = pixel_grb_q;
  assign pixel_index  = pixel_index_q;
  assign frame_done   = frame_done_q;
  assign frame_pixels = frame_pixels_q;
  assign idx_overflow = idx_overflow_q;
  assign sel_grb      = sel_grb_q;
  assign sel_update   = sel_update_q;
`ifdef WS2812B_PARTIAL_ERR_EN
  assign partial_err  = partial_err_q;
`else
  assign partial_err  = 1'b0;
`endif

endmodule
